sad_8r_acc: RTL and testbench

SAD_8R_ACC -- requirements
Module: sad_8r_acc

---
 rtl/sad_pkg.sv | 21 ++
 rtl/row_sad32.sv | 31 +++
 rtl/sad_8r_acc.sv | 141 ++++++++++++++
 tb/tb_sad_8r_acc.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// Shared constants and FSM state type for the 8-row SAD accumulator.
package sad_pkg;

    localparam int unsigned PIXEL    = 8;
    localparam int unsigned X        = 32;
    localparam int unsigned ROWS     = 8;
    localparam int unsigned SAD_W    = 18;
    localparam int unsigned IDX_W    = 7;
    localparam int unsigned ROW_BITS = PIXEL * X;
    localparam int unsigned BUS_W    = ROW_BITS * ROWS;
    localparam int unsigned RSUM_W   = 13;
    localparam int unsigned TOT_W    = 16;

    localparam logic [SAD_W-1:0] SAD_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } sad_state_e;

endpackage

// File: rtl/row_sad32.sv
// One reference row against one current row: 32 absolute differences summed by a balanced tree.
module row_sad32 import sad_pkg::*; (
    input  logic [ROW_BITS-1:0] ref_row_i,
    input  logic [ROW_BITS-1:0] cur_row_i,
    output logic [RSUM_W-1:0]   sum_o
);

    logic [PIXEL-1:0] diff [X];
    logic [8:0]       lvl1 [16];
    logic [9:0]       lvl2 [8];
    logic [10:0]      lvl3 [4];
    logic [11:0]      lvl4 [2];

    always_comb begin
        for (int unsigned p = 0; p < X; p++) begin
            if (ref_row_i[p*PIXEL +: PIXEL] > cur_row_i[p*PIXEL +: PIXEL])
                diff[p] = ref_row_i[p*PIXEL +: PIXEL] - cur_row_i[p*PIXEL +: PIXEL];
            else
                diff[p] = cur_row_i[p*PIXEL +: PIXEL] - ref_row_i[p*PIXEL +: PIXEL];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 16; i++) lvl1[i] = {1'b0, diff[2*i]} + {1'b0, diff[2*i+1]};
        for (int unsigned i = 0; i < 8; i++)  lvl2[i] = {1'b0, lvl1[2*i]} + {1'b0, lvl1[2*i+1]};
        for (int unsigned i = 0; i < 4; i++)  lvl3[i] = {1'b0, lvl2[2*i]} + {1'b0, lvl2[2*i+1]};
        for (int unsigned i = 0; i < 2; i++)  lvl4[i] = {1'b0, lvl3[2*i]} + {1'b0, lvl3[2*i+1]};
        sum_o = {1'b0, lvl4[0]} + {1'b0, lvl4[1]};
    end

endmodule

// File: rtl/sad_8r_acc.sv
// Candidate SAD accumulator: accept 8-row groups, three-stage pipeline, best-match tracking.
module sad_8r_acc import sad_pkg::*; (
    input  logic             clk,
    input  logic             rst,
    input  logic [BUS_W-1:0] ref_8R_32,
    input  logic             Oda8R_va,
    input  logic [BUS_W-1:0] cur_8R_32,
    input  logic             start,
    input  logic [1:0]       num_grp,
    input  logic             clr_best,
    output logic [SAD_W-1:0] sad_out,
    output logic             sad_va,
    output logic [SAD_W-1:0] best_sad,
    output logic [IDX_W-1:0] best_idx,
    output logic             busy
);

    sad_state_e state_q, state_d;
    logic [1:0] grp_q, grp_d, ngrp_q, ngrp_d;
    logic       accept, first, last;
    logic [1:0] eff_cnt, eff_n;

    logic             v0_q, first0_q, last0_q;
    logic [BUS_W-1:0] ref0_q, cur0_q;
    logic             v1_q, first1_q, last1_q;
    logic [RSUM_W-1:0] rsum0 [ROWS];
    logic [RSUM_W-1:0] rsum1_q [ROWS];
    logic [TOT_W-1:0]  total;
    logic [SAD_W-1:0]  acc_q, acc_sum;
    logic [SAD_W-1:0]  sad_out_q, best_sad_q;
    logic              sad_va_q;
    logic [IDX_W-1:0]  best_idx_q, cand_q;

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        ngrp_d  = ngrp_q;
        accept  = 1'b0;
        first   = 1'b0;
        last    = 1'b0;
        eff_cnt = start ? 2'd0 : grp_q;
        eff_n   = start ? num_grp : ngrp_q;
        if (start) begin
            state_d = ACC;
            grp_d   = '0;
            ngrp_d  = num_grp;
        end
        if (Oda8R_va && (start || state_q == ACC)) begin
            accept = 1'b1;
            first  = (eff_cnt == 2'd0);
            last   = (eff_cnt == eff_n);
            if (last) begin
                state_d = IDLE;
                grp_d   = '0;
            end else begin
                grp_d = eff_cnt + 2'd1;
            end
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        row_sad32 u_row (
            .ref_row_i (ref0_q[r*ROW_BITS +: ROW_BITS]),
            .cur_row_i (cur0_q[r*ROW_BITS +: ROW_BITS]),
            .sum_o     (rsum0[r])
        );
    end

    // The first-group flag restarts the sum, so leftovers of an aborted candidate are dropped
    // and a new candidate can enter while the previous one is still draining.
    always_comb begin
        total = '0;
        for (int unsigned i = 0; i < ROWS; i++) total = total + TOT_W'(rsum1_q[i]);
        acc_sum = (first1_q ? '0 : acc_q) + SAD_W'(total);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            ref0_q <= ref_8R_32;
            cur0_q <= cur_8R_32;
        end
        if (v0_q) rsum1_q <= rsum0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grp_q      <= '0;
            ngrp_q     <= '0;
            v0_q       <= 1'b0;
            first0_q   <= 1'b0;
            last0_q    <= 1'b0;
            v1_q       <= 1'b0;
            first1_q   <= 1'b0;
            last1_q    <= 1'b0;
            acc_q      <= '0;
            sad_out_q  <= '0;
            sad_va_q   <= 1'b0;
            best_sad_q <= SAD_MAX;
            best_idx_q <= '0;
            cand_q     <= '0;
        end else begin
            state_q  <= state_d;
            grp_q    <= grp_d;
            ngrp_q   <= ngrp_d;
            v0_q     <= accept;
            first0_q <= first;
            last0_q  <= last;
            v1_q     <= v0_q;
            first1_q <= first0_q;
            last1_q  <= last0_q;
            sad_va_q <= v1_q & last1_q;
            if (v1_q) begin
                if (last1_q) begin
                    sad_out_q <= acc_sum;
                    acc_q     <= '0;
                end else begin
                    acc_q <= acc_sum;
                end
            end
            if (clr_best) begin
                best_sad_q <= SAD_MAX;
                best_idx_q <= '0;
                cand_q     <= '0;
            end else if (sad_va_q) begin
                if (sad_out_q < best_sad_q) begin
                    best_sad_q <= sad_out_q;
                    best_idx_q <= cand_q;
                end
                cand_q <= cand_q + 1'b1;
            end
        end
    end

    assign sad_out  = sad_out_q;
    assign sad_va   = sad_va_q;
    assign best_sad = best_sad_q;
    assign best_idx = best_idx_q;
    assign busy     = (state_q == ACC) | v0_q | v1_q;

endmodule

// File: tb/tb_sad_8r_acc.sv
// Self-checking bench for sad_8r_acc: vector table, scoreboard queue, and corner-case sequences.
module tb_sad_8r_acc;
    import sad_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [BUS_W-1:0] ref_bus = '0;
    logic [BUS_W-1:0] cur_bus = '0;
    logic             oda = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       num_grp = '0;
    logic             clr_best = 1'b0;
    logic [SAD_W-1:0] sad_out;
    logic             sad_va;
    logic [SAD_W-1:0] best_sad;
    logic [IDX_W-1:0] best_idx;
    logic             busy;

    sad_8r_acc dut (
        .clk       (clk),
        .rst       (rst),
        .ref_8R_32 (ref_bus),
        .Oda8R_va  (oda),
        .cur_8R_32 (cur_bus),
        .start     (start),
        .num_grp   (num_grp),
        .clr_best  (clr_best),
        .sad_out   (sad_out),
        .sad_va    (sad_va),
        .best_sad  (best_sad),
        .best_idx  (best_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  r;
        logic [7:0]  c;
        logic [1:0]  ng;
        logic        rnd;
        int unsigned exp;
    } vec_t;

    vec_t             vecs [6];
    logic [SAD_W-1:0] sb [$];
    int unsigned      n_vec = 0;
    int unsigned      n_bad = 0;
    logic [SAD_W-1:0] exp_best = '1;
    logic [IDX_W-1:0] exp_idx = '0;
    logic [IDX_W-1:0] cidx = '0;
    logic [SAD_W-1:0] e;

    task automatic check(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BUS_W-1:0] fill(input logic [7:0] b);
        logic [BUS_W-1:0] res;
        for (int p = 0; p < 256; p++) res[p*8 +: 8] = b;
        return res;
    endfunction

    function automatic logic [BUS_W-1:0] rnd_bus();
        logic [BUS_W-1:0] res;
        for (int p = 0; p < 256; p++) res[p*8 +: 8] = 8'($urandom);
        return res;
    endfunction

    function automatic logic [BUS_W-1:0] mk_bus(input int unsigned total);
        logic [BUS_W-1:0] res;
        int unsigned rem = total;
        for (int p = 0; p < 256; p++) begin
            res[p*8 +: 8] = (rem > 255) ? 8'd255 : 8'(rem);
            rem = rem - ((rem > 255) ? 255 : rem);
        end
        return res;
    endfunction

    function automatic int unsigned sad_of(input logic [BUS_W-1:0] a, input logic [BUS_W-1:0] b);
        int unsigned s = 0;
        for (int p = 0; p < 256; p++) begin
            if (a[p*8 +: 8] > b[p*8 +: 8]) s += int'(a[p*8 +: 8]) - int'(b[p*8 +: 8]);
            else                           s += int'(b[p*8 +: 8]) - int'(a[p*8 +: 8]);
        end
        return s;
    endfunction

    task automatic send(input logic [BUS_W-1:0] r, input logic [BUS_W-1:0] c,
                        input logic st, input logic [1:0] ng);
        ref_bus = r;
        cur_bus = c;
        oda     = 1'b1;
        start   = st;
        num_grp = ng;
        tick();
        oda   = 1'b0;
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        check("drain_timeout", sb.size(), 0);
        sb.delete();
        tick();
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sad_out"}, sad_out, 0);
        check({tag, "_sad_va"}, sad_va, 0);
        check({tag, "_best_sad"}, best_sad, 18'h3FFFF);
        check({tag, "_best_idx"}, best_idx, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Scoreboard pop plus reference best-match model, driven only by bench-side expectations
    always @(negedge clk) begin
        if (rst) begin
            exp_best = '1;
            exp_idx  = '0;
            cidx     = '0;
        end else begin
            if (sad_va) begin
                if (sb.size() == 0) begin
                    check("sad_va_spurious", sad_va, 0);
                end else begin
                    e = sb.pop_front();
                    check("sad_out", sad_out, e);
                    if (!clr_best && e < exp_best) begin
                        exp_best = e;
                        exp_idx  = cidx;
                    end
                end
                cidx = cidx + 1'b1;
            end
            if (clr_best) begin
                exp_best = '1;
                exp_idx  = '0;
                cidx     = '0;
            end
        end
    end

    initial begin
        int unsigned acc;
        logic [BUS_W-1:0] rb, cb;
        int unsigned sads [4];

        vecs[0] = '{8'hFF, 8'h00, 2'd3, 1'b0, 261120};
        vecs[1] = '{8'h10, 8'h30, 2'd1, 1'b0, 16384};
        vecs[2] = '{8'h00, 8'h00, 2'd2, 1'b1, 0};
        vecs[3] = '{8'h80, 8'h7F, 2'd2, 1'b0, 768};
        vecs[4] = '{8'h00, 8'h00, 2'd0, 1'b1, 0};
        vecs[5] = '{8'h03, 8'h01, 2'd0, 1'b0, 512};

        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        sb.push_back(18'd3840);
        send(fill(8'h0F), fill(8'h00), 1'b1, 2'd0);
        tick();
        check("lat_early_va", sad_va, 0);
        tick();
        check("lat_va", sad_va, 1);
        check("lat_sad_out", sad_out, 3840);
        tick();
        tick();
        check("first_best_sad", best_sad, 3840);
        check("first_best_idx", best_idx, 0);

        foreach (vecs[i]) begin
            acc = 0;
            for (int g = 0; g <= int'(vecs[i].ng); g++) begin
                rb = vecs[i].rnd ? rnd_bus() : fill(vecs[i].r);
                cb = vecs[i].rnd ? rnd_bus() : fill(vecs[i].c);
                acc += vecs[i].rnd ? sad_of(rb, cb) : vecs[i].exp / (int'(vecs[i].ng) + 1);
                if (g == int'(vecs[i].ng)) sb.push_back(SAD_W'(acc));
                send(rb, cb, g == 0, vecs[i].ng);
            end
        end
        drain();
        check("table_best_sad", best_sad, exp_best);
        check("table_best_idx", best_idx, exp_idx);

        clr_best = 1'b1;
        tick();
        clr_best = 1'b0;
        check("clr_best_sad", best_sad, 18'h3FFFF);
        check("clr_best_idx", best_idx, 0);

        sads = '{500, 300, 300, 700};
        foreach (sads[i]) begin
            sb.push_back(SAD_W'(sads[i]));
            send(mk_bus(sads[i]), fill(8'h00), 1'b1, 2'd0);
        end
        drain();
        check("tie_best_sad", best_sad, 300);
        check("tie_best_idx", best_idx, 1);

        send(fill(8'h05), fill(8'h00), 1'b1, 2'd3);
        check("abort_busy", busy, 1);
        send(fill(8'h05), fill(8'h00), 1'b0, 2'd3);
        sb.push_back(18'd1024);
        for (int g = 0; g < 4; g++) send(fill(8'h00), fill(8'h01), g == 0, 2'd3);
        drain();
        check("abort_idle_busy", busy, 0);
        check("abort_best_sad", best_sad, exp_best);

        sb.push_back(18'd400);
        send(mk_bus(400), fill(8'h00), 1'b1, 2'd0);
        tick();
        tick();
        clr_best = 1'b1;
        check("clr_coinc_va", sad_va, 1);
        tick();
        clr_best = 1'b0;
        check("clr_coinc_best_sad", best_sad, 18'h3FFFF);
        check("clr_coinc_best_idx", best_idx, 0);
        sb.push_back(18'd600);
        send(mk_bus(600), fill(8'h00), 1'b1, 2'd0);
        sb.push_back(18'd200);
        send(mk_bus(200), fill(8'h00), 1'b1, 2'd0);
        drain();
        check("post_clr_best_sad", best_sad, 200);
        check("post_clr_best_idx", best_idx, 1);
        check("post_clr_model_idx", best_idx, exp_idx);

        send(fill(8'h07), fill(8'h00), 1'b1, 2'd3);
        send(fill(8'h07), fill(8'h00), 1'b0, 2'd3);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        tick();
        tick();
        rst = 1'b0;
        repeat (12) tick();
        check("midrst_best_model", best_sad, exp_best);
        sb.push_back(18'd512);
        send(fill(8'h02), fill(8'h00), 1'b1, 2'd0);
        drain();
        check("midrst_new_best_sad", best_sad, 512);
        check("midrst_new_best_idx", best_idx, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
